// File: rtl/noc_pkg.sv
// Shared mesh-node constants.
// Direction indices give the bit position of each output direction in a
// route mask. NPORT_DEF and FLIT_PYLD_W are the default router geometry
// used by the input buffers.
package noc_pkg;

    typedef enum int unsigned {
        DIR_N = 0,
        DIR_W = 1,
        DIR_S = 2,
        DIR_E = 3,
        DIR_B = 4
    } dir_e;

    localparam int NPORT_DEF   = 5;
    localparam int FLIT_PYLD_W = 23;

endpackage

// File: rtl/ibuf_store.sv
// Register file for the input buffer entries.
// One synchronous write port, one asynchronous read port, async reset to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   we         : write enable
//   waddr      : write address
//   wdata      : write data
//   raddr      : read address
//   rdata      : read data (combinational from raddr)
module ibuf_store #(
    parameter  int WIDTH  = 28,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ibuf_fifo.sv
// Multi-entry router input buffer with multicast head retirement.
// Flits {route, payload} are queued in order. The head's not-yet-served
// directions are offered to the output arbiters; the head retires once
// every direction in its route has been granted with output-buffer ready.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous clear of entries and served state
//   in_vld/in_rdy, in_route, in_pyld : upstream flit handshake
//   arb_req      : head's outstanding directions
//   arb_gnt, obuf_rdy : per-direction grant and downstream ready
//   out_pyld     : head payload
//   occ          : number of stored flits
module ibuf_fifo
    import noc_pkg::*;
#(
    parameter  int PYLD_W = FLIT_PYLD_W,
    parameter  int NPORT  = NPORT_DEF,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [NPORT-1:0]  in_route,
    input  logic [PYLD_W-1:0] in_pyld,
    output logic [NPORT-1:0]  arb_req,
    input  logic [NPORT-1:0]  arb_gnt,
    input  logic [NPORT-1:0]  obuf_rdy,
    output logic [PYLD_W-1:0] out_pyld,
    output logic [CNT_W-1:0]  occ
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               ENT_W    = NPORT + PYLD_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q,  count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [NPORT-1:0] served_q, served_d;

    logic [ENT_W-1:0]  head_ent;
    logic [NPORT-1:0]  head_route;
    logic [NPORT-1:0]  clr;
    logic              push;
    logic              pop;
    logic              wr_en;

    ibuf_store #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({in_route, in_pyld}),
        .raddr (rd_ptr_q),
        .rdata (head_ent)
    );

    assign head_route = head_ent[ENT_W-1:PYLD_W];
    assign out_pyld   = head_ent[PYLD_W-1:0];

    // Registers only: no path from in_* or arb_gnt/obuf_rdy to outputs.
    assign in_rdy  = (count_q != FULL_CNT);
    assign arb_req = (count_q != '0) ? (head_route & ~served_q) : '0;
    assign occ     = count_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        served_d = served_q;

        // Zero-route flits complete the handshake but are dropped.
        push  = in_vld & in_rdy & (|in_route);
        clr   = arb_gnt & obuf_rdy & arb_req;
        pop   = (|clr) & ((head_route & ~(served_q | clr)) == '0);
        wr_en = push & ~flush;

        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            served_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                served_d = '0;
            end else if (|clr) begin
                served_d = served_q | clr;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            served_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            served_q <= served_d;
        end
    end

endmodule

// File: tb/tb_ibuf_fifo.sv
module tb_ibuf_fifo;
    import noc_pkg::*;

    localparam int PW = 23;
    localparam int NP = 5;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_vld;
    logic          in_rdy;
    logic [NP-1:0] in_route;
    logic [PW-1:0] in_pyld;
    logic [NP-1:0] arb_req;
    logic [NP-1:0] arb_gnt;
    logic [NP-1:0] obuf_rdy;
    logic [PW-1:0] out_pyld;
    logic [CW-1:0] occ;

    int n_checks = 0;
    int n_fail   = 0;

    ibuf_fifo #(
        .PYLD_W (PW),
        .NPORT  (NP),
        .DEPTH  (DP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_route (in_route),
        .in_pyld  (in_pyld),
        .arb_req  (arb_req),
        .arb_gnt  (arb_gnt),
        .obuf_rdy (obuf_rdy),
        .out_pyld (out_pyld),
        .occ      (occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of flits plus the set of directions
    // already delivered for the front flit.
    typedef struct packed {
        logic [NP-1:0] route;
        logic [PW-1:0] pyld;
    } flit_t;

    flit_t         mq[$];
    logic [NP-1:0] m_served;

    initial begin
        logic [NP-1:0] req;
        logic [NP-1:0] done;
        bit            was_full;
        m_served = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_served = '0;
            end else if (flush) begin
                mq.delete();
                m_served = '0;
            end else begin
                was_full = (mq.size() == DP);
                if (mq.size() != 0) begin
                    req  = mq[0].route & ~m_served;
                    done = arb_gnt & obuf_rdy & req;
                    if (done != '0) begin
                        if ((m_served | done) == (m_served | mq[0].route)) begin
                            void'(mq.pop_front());
                            m_served = '0;
                        end else begin
                            m_served = m_served | done;
                        end
                    end
                end
                if (in_vld && !was_full && in_route != '0) begin
                    mq.push_back('{route: in_route, pyld: in_pyld});
                end
            end
        end
    end

    // Monitor: compare DUT outputs against the model mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            check("occ", 32'(occ), 32'(mq.size()));
            check("in_rdy", 32'(in_rdy), 32'(mq.size() != DP));
            if (mq.size() == 0) begin
                check("arb_req_empty", 32'(arb_req), 32'd0);
            end else begin
                check("arb_req", 32'(arb_req), 32'(mq[0].route & ~m_served));
                check("out_pyld", 32'(out_pyld), 32'(mq[0].pyld));
            end
        end
    end

    task automatic drive(input logic v, input logic [NP-1:0] r, input logic [PW-1:0] p,
                         input logic [NP-1:0] g, input logic [NP-1:0] o, input logic f);
        in_vld   = v;
        in_route = r;
        in_pyld  = p;
        arb_gnt  = g;
        obuf_rdy = o;
        flush    = f;
        @(posedge clk);
        #2;
    endtask

    localparam logic [NP-1:0] U0 = NP'(1 << DIR_N);
    localparam logic [NP-1:0] MC = NP'((1 << DIR_N) | (1 << DIR_S) | (1 << DIR_B));

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_vld   = 1'b0;
        in_route = '0;
        in_pyld  = '0;
        arb_gnt  = '0;
        obuf_rdy = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        check("rst_arb_req", 32'(arb_req), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_out_pyld", 32'(out_pyld), 32'd0);
        rst_n = 1'b1;
        drive(0, '0, '0, '0, '0, 0);
        drive(0, '0, '0, '0, '0, 0);
        check("idle_out_pyld", 32'(out_pyld), 32'd0);

        // Async reset mid-traffic with three stored flits.
        for (int i = 1; i <= 3; i++) drive(1, U0, PW'(i + 40), '0, '0, 0);
        drive(0, '0, '0, '0, '0, 0);
        check("pre_rst_occ", 32'(occ), 32'd3);
        rst_n = 1'b0;
        #1;
        check("arst_in_rdy", 32'(in_rdy), 32'd1);
        check("arst_arb_req", 32'(arb_req), 32'd0);
        check("arst_occ", 32'(occ), 32'd0);
        check("arst_out_pyld", 32'(out_pyld), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(0, '0, '0, '0, '0, 0);

        // Fill with unicast, attempt a fifth, then drain one per cycle.
        for (int i = 1; i <= 4; i++) drive(1, U0, PW'(i), '0, '0, 0);
        check("full_occ", 32'(occ), 32'd4);
        check("full_in_rdy", 32'(in_rdy), 32'd0);
        drive(1, U0, PW'(5), '0, '0, 0);
        check("fifth_rejected", 32'(occ), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_pyld", 32'(out_pyld), 32'(i));
            drive(0, '0, '0, U0, U0, 0);
            if (i == 1) check("rdy_after_pop", 32'(in_rdy), 32'd1);
        end
        check("drained_occ", 32'(occ), 32'd0);

        // Multicast served over three separate grants.
        drive(1, MC, PW'(77), '0, '1, 0);
        check("mc_req0", 32'(arb_req), 32'(MC));
        drive(0, '0, '0, NP'(1 << DIR_N), '1, 0);
        check("mc_req1", 32'(arb_req), 32'b10100);
        drive(0, '0, '0, '0, '1, 0);
        drive(0, '0, '0, NP'(1 << DIR_B), '1, 0);
        check("mc_req3", 32'(arb_req), 32'b00100);
        check("mc_occ3", 32'(occ), 32'd1);
        drive(0, '0, '0, '0, '1, 0);
        drive(0, '0, '0, NP'(1 << DIR_S), '1, 0);
        check("mc_popped", 32'(occ), 32'd0);

        // Grant without ready, and grant on an unrequested direction.
        drive(1, U0, PW'(9), '0, '0, 0);
        drive(0, '0, '0, U0, '0, 0);
        drive(0, '0, '0, NP'(1 << DIR_W), '1, 0);
        check("nogrant_occ", 32'(occ), 32'd1);
        check("nogrant_req", 32'(arb_req), 32'(U0));
        drive(0, '0, '0, U0, U0, 0);

        // Push while full and popping; zero route; flush with push.
        for (int i = 1; i <= 4; i++) drive(1, U0, PW'(i + 20), '0, '0, 0);
        drive(1, U0, PW'(99), U0, U0, 0);
        check("full_pop_push", 32'(occ), 32'd3);
        drive(1, '0, PW'(98), '0, '0, 0);
        check("zero_route", 32'(occ), 32'd3);
        drive(0, '0, '0, U0, U0, 0);
        check("pre_flush", 32'(occ), 32'd2);
        drive(1, U0, PW'(97), '0, '0, 1);
        check("flush_occ", 32'(occ), 32'd0);
        check("flush_req", 32'(arb_req), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 7),
                  NP'($urandom_range(0, 31)),
                  PW'($urandom),
                  NP'($urandom),
                  NP'($urandom | $urandom),
                  ($urandom_range(0, 63) == 0));
        end
        drive(0, '0, '0, '0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibuf_fifo.md
# ibuf_fifo

Parametrised multi-entry input buffer for one router input port of the mesh node, successor to the single-entry input buffer. Accepts flits with a multicast route mask via valid/ready, stores up to DEPTH flits in order, and presents the head flit's outstanding directions to the per-output arbiters. The head is retired only after every requested direction has been served (grant plus output-buffer ready), so multicast completes across cycles while later flits wait behind it.

## Interface
- PYLD_W, 23, payload width in bits
- NPORT, 5, number of output directions, bit i = direction i (N=0, W=1, S=2, E=3, B=4 for NPORT=5)
- DEPTH, 4, entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), occupancy width (derived, not overridden)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of all entries and served state
- in_vld  in  1  upstream flit valid
- in_rdy  out  1  buffer can accept a flit this cycle
- in_route  in  NPORT  route mask for the flit, multicast allowed
- in_pyld  in  PYLD_W  flit payload
- arb_req  out  NPORT  head flit's not-yet-served directions
- arb_gnt  in  NPORT  per-direction grant from output arbiters
- obuf_rdy  in  NPORT  per-direction output-buffer ready
- out_pyld  out  PYLD_W  head flit payload
- occ  out  CNT_W  number of stored flits

## Operation
- Storage: DEPTH entries of {route, payload}, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH, count register 0..DEPTH.
- push = in_vld & in_rdy & (in_route != 0). A handshake with in_route == 0 is accepted and discarded: nothing stored, occ unchanged.
- in_rdy = (count != DEPTH). It is a function of registers only. A full buffer does not accept a push even if the head pops that cycle.
- served: NPORT-bit register holding the directions already delivered for the head.
- arb_req = route[rd_ptr] & ~served when count != 0, else 0. out_pyld = payload[rd_ptr] (asynchronous read; 0 when never written).
- clr = arb_gnt & obuf_rdy & arb_req. Grant bits outside arb_req are ignored.
- If clr != 0 and (route[rd_ptr] & ~(served | clr)) == 0, pop: rd_ptr+1 and served <= 0. Else, if clr != 0, served <= served | clr.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Push into an empty buffer: the entry becomes head, with arb_req visible the next cycle.
- flush: count, pointers and served go to 0. Priority over push and pop in the same cycle; a push coinciding with flush is lost.
- Reset: count=0, wr_ptr=rd_ptr=0, served=0, storage=0. Outputs: in_rdy=1, arb_req=0, out_pyld=0, occ=0.

## Timing
- Push-to-request latency: 1 cycle. A flit pushed at edge k gives arb_req at k (if it becomes head).
- Unicast head served at edge k. The next head's arb_req is valid after edge k, giving one flit per cycle sustained throughput.
- A multicast to m directions granted in separate cycles retires on the edge of the last grant. Partially served bits drop from arb_req the cycle after their grant.
- occ and in_rdy update on the same edge as the count change. After a pop from full, in_rdy=1 the next cycle.
- No combinational path from in_* to in_rdy, or from arb_gnt/obuf_rdy to any output.

## Structure
- Shared package noc_pkg: DIR_N/W/S/E/B constants, NPORT default, flit payload width constant.
- One sub-module: ibuf_store, a DEPTH×(NPORT+PYLD_W) register file with 1 write port, 1 async read port and async reset. Pointer, count, served and handshake logic stay in ibuf_fifo.

## Test plan
- Reset, then idle: in_rdy=1, arb_req=0, occ=0, out_pyld=0. Assert rst_n low mid-traffic with occ=3: all of these return immediately.
- Push 4 unicast flits (route 5'b00001, payloads 1..4) with obuf_rdy=0: occ=4, in_rdy=0, and a 5th in_vld is not accepted. Then hold gnt=obuf_rdy=5'b00001: payloads 1,2,3,4 appear on out_pyld on consecutive cycles, and in_rdy=1 one cycle after the first pop.
- Multicast route 5'b10101: grant bit 0 at cycle 1, bit 4 at cycle 3, bit 2 at cycle 5. arb_req goes 10101 → 10100 → 00100, and the pop happens on the cycle-5 edge only.
- arb_gnt=5'b00001 with obuf_rdy=5'b00000, and gnt on a non-requested bit: no change to served or occ.
- Full buffer, push attempted on the same cycle as a head pop: push rejected, occ=3. A zero-route handshake gives occ unchanged. flush with occ=2 and push asserted gives occ=0 and arb_req=0 the next cycle.
